// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM encoding (ARB_IDLE / ARB_BURST)
//   clog2       : pointer width helper, never returns less than 1
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : highest-priority index; the scan runs upward from here with wrap
//   pick : one-hot winner, zero when nothing is requested
//   any  : at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        idx   = 0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the single write port of the team fifo among NUM_REQ framed
// producers. Owners are chosen round-robin and keep the port until the
// last beat of their burst. Occupancy is tracked from the push/pop strobes
// and writes are throttled at DEPTH-1 words, because the fifo overruns
// silently beyond that.
//   req_data/req_valid/req_last : producer streams, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack                     : lane word written this cycle
//   fifo_in/fifo_in_latch       : to fifo write side
//   fifo_out_latch/out_valid    : copies of the fifo read side, for occupancy
//   grant/busy/level            : current owner, burst active, words stored
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         fifo_in,
    output logic                          fifo_in_latch,
    input  logic                          fifo_out_latch,
    input  logic                          fifo_out_valid,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [DEPTH_LOG2-1:0]         level
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam logic [DEPTH_LOG2-1:0] LEVEL_MAX = '1;  // DEPTH-1

    arb_state_t                         state;
    logic [PTR_W-1:0]                   owner;
    logic [PTR_W-1:0]                   rr_ptr;
    logic [NUM_REQ-1:0]                 pick;
    logic                               any;
    logic [PTR_W-1:0]                   pick_idx;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_v;
    logic                               space;
    logic                               push;
    logic                               pop;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick[i]) pick_idx = PTR_W'(i);
    end

    assign data_v = req_data;
    // owner resets to 0, so fifo_in shows lane 0 while idle after reset.
    assign fifo_in = data_v[owner];

    // Registered level only: a pop in this cycle frees space next cycle.
    assign space         = level < LEVEL_MAX;
    assign req_ack       = (state == ARB_BURST && req_valid[owner] && space) ? grant : '0;
    assign fifo_in_latch = |req_ack;
    assign busy          = (state == ARB_BURST);

    assign push = fifo_in_latch;
    assign pop  = fifo_out_latch && fifo_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        grant <= pick;
                        owner <= pick_idx;
                        state <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (fifo_in_latch && req_last[owner]) begin
                        grant  <= '0;
                        state  <= ARB_IDLE;
                        rr_ptr <= (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + PTR_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + DEPTH_LOG2'(1);
                2'b01:   if (level != '0) level <= level - DEPTH_LOG2'(1);
                default: level <= level;
            endcase
        end
    end

    // A pop from an empty fifo means fifo_out_valid is wrong upstream.
    pop_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && level == '0));

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares one write port of the team's single-clock `fifo` among `NUM_REQ` producer streams, such as MBus RX, UART RX and GPIO event sources. Producers present framed bursts and are granted round-robin. A granted producer keeps the write port until its `last` beat so bursts never interleave. The block also tracks FIFO occupancy from the push/pop strobes and throttles writes, because the FIFO itself has no full flag and silently overruns at `DEPTH-1` entries.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `NUM_REQ`, 4, number of producers, 2..8.
- `DEPTH_LOG2`, 4, log2 of the FIFO depth; must match the FIFO. Usable capacity is `(1<<DEPTH_LOG2)-1` words.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req_data` in `NUM_REQ*DATA_WIDTH`: producer i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid` in `NUM_REQ`: producer i has a word.
- `req_last` in `NUM_REQ`: the current word of producer i ends its burst.
- `req_ack` out `NUM_REQ`: the word of producer i is written this cycle.
- `fifo_in` out `DATA_WIDTH`: to FIFO `in`.
- `fifo_in_latch` out 1: to FIFO `in_latch`.
- `fifo_out_latch` in 1: copy of the FIFO reader's `out_latch`.
- `fifo_out_valid` in 1: copy of FIFO `out_valid`.
- `grant` out `NUM_REQ`: one-hot current owner; all zero when idle.
- `busy` out 1: a burst is in progress.
- `level` out `DEPTH_LOG2`: words currently in the FIFO.

## Operation
- State `IDLE`:
  - If any `req_valid` is set, pick the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - Register the pick into `grant` and go to `BURST`. No ack is issued in `IDLE`.
- State `BURST` with owner g:
  - `req_ack[g] = req_valid[g] && (level < DEPTH-1)`. All other ack bits are 0.
  - `fifo_in = req_data[g]`, and `fifo_in_latch = |req_ack`, both combinational.
  - On an ack with `req_last[g]=1`: go to `IDLE`, clear `grant`, set `rr_ptr = g+1` (mod `NUM_REQ`).
  - `req_valid[g]` low mid-burst: hold ownership and wait. There is no timeout.
- Occupancy:
  - push = `fifo_in_latch`; pop = `fifo_out_latch && fifo_out_valid`.
  - `level` increments on push only, decrements on pop only, and is unchanged on both or neither.
- Space check uses the registered `level`. A pop in the same cycle does not free space until the next cycle, which is deliberately conservative.
- `level` never exceeds `DEPTH-1`, because of the throttle. `level==0` with a pop is impossible when `fifo_out_valid` is correct. Saturate at 0 and flag this in simulation only.
- `busy = (state==BURST)`.
- Reset is synchronous, active-high, and overrides everything:
  - `state=IDLE`, `grant=0`, `rr_ptr=0`, `level=0`.
  - Hence `req_ack=0`, `fifo_in_latch=0`, `busy=0`.
  - `fifo_in` reads as `req_data[0]`; this is don't-care but deterministic.
  - Reset mid-burst aborts the burst with no further acks. The FIFO must be reset in the same cycle.

## Timing
- Arbitration costs 1 cycle. `req_valid` rising in cycle n gives `grant` in n+1 and the earliest ack in n+1.
- Throughput in `BURST` is 1 word/cycle while valid and space allow.
- There is 1 idle cycle between consecutive bursts, including bursts from the same producer.
- Single-word burst (`req_last` on the first word): `grant` lasts exactly 1 cycle.
- The FIFO write lands at the clock edge ending the ack cycle. `level` reflects it in the next cycle.
- Full throttle: with `level==DEPTH-1`, ack is 0. If a pop occurs in cycle n, the ack may resume in n+1.

## Structure
- Package `fifo_arb_pkg`:
  - state encoding constants `ARB_IDLE` and `ARB_BURST`;
  - function `clog2` for `rr_ptr` width.
- Sub-module `rr_pick`: purely combinational round-robin picker.
  - Inputs: `req[NUM_REQ]`, `ptr`.
  - Outputs: one-hot `pick` and `any`.
  - Reused by future arbiters.
- Top level holds the FSM, `rr_ptr`, the grant register, the data mux and the occupancy counter. It is instantiated next to `fifo` with DATA_WIDTH and DEPTH_LOG2 passed identically.

## Test plan
- Reset then single producer: producer 1 sends 3 words 0x11,0x22,0x33 (last on 0x33).
  - `grant=4'b0010` for 3 cycles, acks in consecutive cycles, FIFO pops 0x11,0x22,0x33.
  - `rr_ptr` becomes 2 and `level` returns to 0 after 3 pops.
- All 4 producers valid, 2-word bursts, starting from reset: grant order is 0,1,2,3,0.
  - Bursts never interleave.
  - There is exactly 1 idle cycle between grants.
- Full throttle with DEPTH_LOG2=4 and no pops: producer 0 streams 20 words.
  - Exactly 15 acks, then `req_ack` stays 0 and `level=15`.
  - One pop restores 1 ack on the following cycle, then `level=15` again.
- Simultaneous push and pop at `level=7` for 5 cycles: `level` stays 7.
  - Data pops in write order.
- Owner stalls: producer 2 drops `req_valid` for 4 cycles mid-burst while producer 3 is valid.
  - `grant` stays on 2 and no ack goes to 3.
  - Burst resumes and completes.
- Reset asserted mid-burst after 2 of 5 words: the next cycle has `busy=0`, `grant=0`, `level=0`, and no `fifo_in_latch`.
  - Arbitration then restarts from producer 0.
